// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected score path.
// Defaults, class index width and argmax FSM states.
package fc_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int SCORE_W     = 32;
  localparam int CLASS_W     = $clog2(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fc_argmax_decoder_if.sv
// Frame-in / result-out handshake bundle for the argmax decoder.
// Optional margin signal present when ARGMAX_MARGIN_EN is defined.
interface fc_argmax_decoder_if #(
  parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES,
  parameter int SCORE_W     = fc_pkg::SCORE_W,
  parameter int CNT_W       = 16
);

  localparam int CW = $clog2(NUM_CLASSES);

  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CLASSES*SCORE_W-1:0] scores_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [CW-1:0]                  class_idx;
  logic [SCORE_W-1:0]             max_score;
  logic [CNT_W-1:0]               dec_count;
`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0]             margin;
`endif

  modport master (
    output in_valid,
    output scores_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  class_idx,
    input  max_score,
`ifdef ARGMAX_MARGIN_EN
    input  margin,
`endif
    input  dec_count
  );

  modport slave (
    input  in_valid,
    input  scores_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output class_idx,
    output max_score,
`ifdef ARGMAX_MARGIN_EN
    output margin,
`endif
    output dec_count
  );

endinterface

// File: rtl/fc_cmp_stage.sv
// One argmax step: fold a score into {best, best_idx[, second]}.
// Strict greater-than keeps the lower index on ties.
module fc_cmp_stage #(
  parameter int SCORE_W = fc_pkg::SCORE_W,
  parameter int CW      = fc_pkg::CLASS_W
) (
  input  logic [SCORE_W-1:0] score,
  input  logic [CW-1:0]      idx,
  input  logic [SCORE_W-1:0] best_i,
  input  logic [CW-1:0]      bidx_i,
`ifdef ARGMAX_MARGIN_EN
  input  logic [SCORE_W-1:0] second_i,
  output logic [SCORE_W-1:0] second_o,
`endif
  output logic [SCORE_W-1:0] best_o,
  output logic [CW-1:0]      bidx_o
);

  // New best displaces old best into second place
  always_comb begin
    best_o = best_i;
    bidx_o = bidx_i;
`ifdef ARGMAX_MARGIN_EN
    second_o = second_i;
`endif
    if (score > best_i) begin
      best_o = score;
      bidx_o = idx;
`ifdef ARGMAX_MARGIN_EN
      second_o = best_i;
    end else if (score > second_i) begin
      second_o = score;
`endif
    end
  end

endmodule

// File: rtl/fc_argmax_decoder.sv
// Sequential argmax over one frame of class scores, one per cycle.
// Build option ARGMAX_MARGIN_EN adds the best-minus-second margin.
module fc_argmax_decoder #(
  parameter int NUM_CLASSES = fc_pkg::NUM_CLASSES,
  parameter int SCORE_W     = fc_pkg::SCORE_W,
  parameter int CNT_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  fc_argmax_decoder_if.slave bus
);

  import fc_pkg::*;

  localparam int CW = $clog2(NUM_CLASSES);
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);

  state_t state_q;
  state_t state_d;

  logic [SCORE_W-1:0] sc_q [NUM_CLASSES];
  logic [CW-1:0]      idx_q;
  logic [SCORE_W-1:0] best_q;
  logic [CW-1:0]      bidx_q;
  logic [CW-1:0]      cls_q;
  logic [SCORE_W-1:0] max_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [SCORE_W-1:0] best_n;
  logic [CW-1:0]      bidx_n;

`ifdef ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] sec_q;
  logic [SCORE_W-1:0] sec_n;
  logic [SCORE_W-1:0] mrg_q;
`endif

  logic accept;
  logic release_q;
  logic last;

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign release_q = bus.out_ready && (state_q == HOLD);
  assign last      = (idx_q == LAST);

  fc_cmp_stage #(
    .SCORE_W (SCORE_W),
    .CW      (CW)
  ) u_cmp (
    .score    (sc_q[idx_q]),
    .idx      (idx_q),
    .best_i   (best_q),
    .bidx_i   (bidx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_i (sec_q),
    .second_o (sec_n),
`endif
    .best_o   (best_n),
    .bidx_o   (bidx_n)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: capture, scan all classes, hold until taken
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): if (bus.in_valid) state_d = SCAN;
      (state_q == SCAN): if (last) state_d = HOLD;
      (state_q == HOLD): if (bus.out_ready) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // Frame capture, running best and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLASSES; k++) sc_q[k] <= '0;
      idx_q  <= '0;
      best_q <= '0;
      bidx_q <= '0;
      cls_q  <= '0;
      max_q  <= '0;
`ifdef ARGMAX_MARGIN_EN
      sec_q  <= '0;
      mrg_q  <= '0;
`endif
    end else if (accept) begin
      for (int k = 0; k < NUM_CLASSES; k++)
        sc_q[k] <= bus.scores_in[k*SCORE_W +: SCORE_W];
      best_q <= bus.scores_in[SCORE_W-1:0];
      bidx_q <= '0;
      idx_q  <= CW'(1);
`ifdef ARGMAX_MARGIN_EN
      sec_q  <= '0;
`endif
    end else if (state_q == SCAN) begin
      best_q <= best_n;
      bidx_q <= bidx_n;
      idx_q  <= idx_q + CW'(1);
`ifdef ARGMAX_MARGIN_EN
      sec_q  <= sec_n;
`endif
      if (last) begin
        cls_q <= bidx_n;
        max_q <= best_n;
`ifdef ARGMAX_MARGIN_EN
        mrg_q <= best_n - sec_n;
`endif
      end
    end
  end

  // Count results taken downstream, wrapping silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (release_q) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.class_idx = cls_q;
  assign bus.max_score = max_q;
  assign bus.dec_count = cnt_q;
`ifdef ARGMAX_MARGIN_EN
  assign bus.margin    = mrg_q;
`endif

endmodule

// File: tb/tb_fc_argmax_decoder.sv
// Randomized self-checking bench for fc_argmax_decoder.
// Checks margin too when ARGMAX_MARGIN_EN is defined.
module tb_fc_argmax_decoder;

  localparam int NC   = 4;
  localparam int SW   = 32;
  localparam int CNTW = 8;

  typedef logic [SW-1:0] frame_t [NC];

  logic clk;
  logic rst_n;

  int n_chk;
  int n_pass;

  logic [CNTW-1:0] exp_cnt;

  fc_argmax_decoder_if #(
    .NUM_CLASSES (NC),
    .SCORE_W     (SW),
    .CNT_W       (CNTW)
  ) bus ();

  fc_argmax_decoder #(
    .NUM_CLASSES (NC),
    .SCORE_W     (SW),
    .CNT_W       (CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NC*SW-1:0] pack(input frame_t s);
    logic [NC*SW-1:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[k*SW +: SW] = s[k];
    return v;
  endfunction

  // Reference: maximum value, then its first occurrence
  function automatic void model(input frame_t s,
                                output int bi,
                                output logic [SW-1:0] bm);
    bm = s[0];
    for (int k = 1; k < NC; k++) if (s[k] > bm) bm = s[k];
    bi = 0;
    for (int k = NC - 1; k >= 0; k--) if (s[k] == bm) bi = k;
  endfunction

`ifdef ARGMAX_MARGIN_EN
  // Reference margin: winner minus largest of the other entries
  function automatic logic [SW-1:0] margin_of(input frame_t s);
    int bi;
    logic [SW-1:0] bm;
    logic [SW-1:0] sec;
    model(s, bi, bm);
    sec = '0;
    for (int k = 0; k < NC; k++)
      if (k != bi && s[k] > sec) sec = s[k];
    return bm - sec;
  endfunction
`endif

  task automatic run_frame(input frame_t s,
                           input int hold,
                           input bit junk);
    int t;
    int lat;
    int bi;
    logic [SW-1:0] bm;
    model(s, bi, bm);
    @(negedge clk);
    t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.scores_in = pack(s);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.scores_in = '0;
    chk("in_ready_busy", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, NC - 1);
    chk("class_idx", bus.class_idx, bi);
    chk("max_score", bus.max_score, bm);
`ifdef ARGMAX_MARGIN_EN
    chk("margin", bus.margin, margin_of(s));
`endif
    if (junk) begin
      bus.in_valid  = 1'b1;
      bus.scores_in = '1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_ready", bus.in_ready, 0);
      chk("hold_idx", bus.class_idx, bi);
      chk("hold_cnt", bus.dec_count, exp_cnt);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.scores_in = '0;
    exp_cnt++;
    chk("out_valid_drop", bus.out_valid, 0);
    chk("dec_count", bus.dec_count, exp_cnt);
    chk("in_ready_back", bus.in_ready, 1);
  endtask

  initial begin
    frame_t f;
    n_chk   = 0;
    n_pass  = 0;
    exp_cnt = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.scores_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_class_idx", bus.class_idx, 0);
    chk("rst_max_score", bus.max_score, 0);
    chk("rst_dec_count", bus.dec_count, 0);
`ifdef ARGMAX_MARGIN_EN
    chk("rst_margin", bus.margin, 0);
`endif
    rst_n = 1'b1;

    f = '{32'd10, 32'd50, 32'd20, 32'd5};
    run_frame(f, 0, 1'b0);
    f = '{32'd7, 32'd9, 32'd9, 32'd3};
    run_frame(f, 1, 1'b0);
    f = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    run_frame(f, 10, 1'b1);
    f = '{32'd100, 32'd40, 32'd90, 32'd95};
    run_frame(f, 0, 1'b0);

    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_out_ready", bus.dec_count, exp_cnt);
    chk("idle_no_valid", bus.out_valid, 0);

    f = '{32'd8, 32'd6, 32'd4, 32'd2};
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.scores_in = pack(f);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_cnt = '0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_cnt", bus.dec_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_quiet", bus.out_valid, 0);
    end
    f = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_frame(f, 0, 1'b0);

    for (int n = 0; n < (1 << CNTW); n++) begin
      for (int k = 0; k < NC; k++) begin
        case ($urandom_range(0, 2))
          0:       f[k] = $urandom;
          1:       f[k] = SW'($urandom_range(0, 3));
          default: f[k] = SW'($urandom_range(0, 1000));
        endcase
      end
      run_frame(f, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    chk("wrap", bus.dec_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
